lock_cmd_arbiter: RTL and testbench

LOCK_CMD_ARBITER -- requirements
Module: lock_cmd_arbiter

---
 rtl/lock_cmd_arbiter_pkg.sv | 13 +
 rtl/lock_cmd_arbiter_rr_grant.sv | 31 +++
 rtl/lock_cmd_arbiter.sv | 67 ++++++
 tb/tb_lock_cmd_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_cmd_arbiter_pkg.sv
// Command-word definitions shared by the OmpSs manager blocks.
// The lock-command arbiter forwards these words unmodified.
package OmpSsManager;

   localparam int unsigned CMD_W      = 64;
   localparam int unsigned CMD_CODE_W = 8;

   typedef struct packed {
      logic [CMD_W-CMD_CODE_W-1:0] args;
      logic [CMD_CODE_W-1:0]       code;
   } cmd_t;

endpackage

// File: rtl/lock_cmd_arbiter_rr_grant.sv
// Round-robin priority search: first requesting lane strictly after last_grant,
// wrapping at N so the index stays below N for any lane count.
module rr_grant #(
   parameter  int unsigned N = 16,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_grant,
   output logic [W-1:0] grant,
   output logic         any_req
);

   always_comb begin
      int unsigned idx;
      logic [W-1:0] idx_w;
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      idx_w   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= N) idx = idx - N;
         idx_w = W'(idx);
         if (!any_req && req[idx_w]) begin
            any_req = 1'b1;
            grant   = idx_w;
         end
      end
   end

endmodule

// File: rtl/lock_cmd_arbiter.sv
// Fair round-robin funnel of per-accelerator lock commands into one
// registered single-beat output stream tagged with the source lane.
module lock_cmd_arbiter
   import OmpSsManager::*;
#(
   parameter  int unsigned MAX_ACCS = 16,
   localparam int unsigned ACC_BITS = $clog2(MAX_ACCS)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [MAX_ACCS*CMD_W-1:0] inStream_TDATA,
   input  logic [MAX_ACCS-1:0]       inStream_TVALID,
   output logic [MAX_ACCS-1:0]       inStream_TREADY,
   output logic [CMD_W-1:0]          outStream_TDATA,
   output logic                      outStream_TVALID,
   input  logic                      outStream_TREADY,
   output logic [ACC_BITS-1:0]       outStream_TID
);

   logic                out_valid;
   cmd_t                out_data;
   logic [ACC_BITS-1:0] out_tid;
   logic [ACC_BITS-1:0] last_grant;
   logic [ACC_BITS-1:0] grant_c;
   logic                any_req_c;
   logic                load_en_c;
   logic                hs_c;
   cmd_t                lane_cmd_c;

   rr_grant #(.N(MAX_ACCS)) u_rr_grant (
      .req        (inStream_TVALID),
      .last_grant (last_grant),
      .grant      (grant_c),
      .any_req    (any_req_c)
   );

   // Output slot is free when empty or being drained this cycle.
   assign load_en_c  = !out_valid || outStream_TREADY;
   assign hs_c       = rstn && load_en_c && any_req_c;
   assign lane_cmd_c = inStream_TDATA[CMD_W*grant_c +: CMD_W];

   always_comb begin
      inStream_TREADY = '0;
      if (hs_c) inStream_TREADY[grant_c] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tid    <= '0;
         last_grant <= ACC_BITS'(MAX_ACCS-1);
      end else if (load_en_c) begin
         out_valid <= any_req_c;
         if (any_req_c) begin
            out_data   <= lane_cmd_c;
            out_tid    <= grant_c;
            last_grant <= grant_c;
         end
      end
   end

   assign outStream_TDATA  = out_data;
   assign outStream_TVALID = out_valid;
   assign outStream_TID    = out_tid;

endmodule

// File: tb/tb_lock_cmd_arbiter.sv
// Bench for lock_cmd_arbiter: a 16-lane and a 5-lane instance, vector table,
// hand sequences for stall/fairness/wrap/reset, and a random run vs a model.
module tb_lock_cmd_arbiter;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [16*64-1:0] a_tdata;
   logic [15:0]      a_tvalid, a_tready;
   logic [63:0]      a_odata;
   logic             a_ovalid, a_oready;
   logic [3:0]       a_tid;

   logic [5*64-1:0]  b_tdata;
   logic [4:0]       b_tvalid, b_tready;
   logic [63:0]      b_odata;
   logic             b_ovalid, b_oready;
   logic [2:0]       b_tid;

   lock_cmd_arbiter #(.MAX_ACCS(16)) dut16 (
      .clk(clk), .rstn(rstn),
      .inStream_TDATA(a_tdata), .inStream_TVALID(a_tvalid), .inStream_TREADY(a_tready),
      .outStream_TDATA(a_odata), .outStream_TVALID(a_ovalid),
      .outStream_TREADY(a_oready), .outStream_TID(a_tid));

   lock_cmd_arbiter #(.MAX_ACCS(5)) dut5 (
      .clk(clk), .rstn(rstn),
      .inStream_TDATA(b_tdata), .inStream_TVALID(b_tvalid), .inStream_TREADY(b_tready),
      .outStream_TDATA(b_odata), .outStream_TVALID(b_ovalid),
      .outStream_TREADY(b_oready), .outStream_TID(b_tid));

   int n_chk = 0;
   int n_pass = 0;

   // Reference: index 0 models the 16-lane instance, index 1 the 5-lane one.
   int          m_last[2];
   bit          m_valid[2];
   logic [63:0] m_data[2];
   int          m_tid[2];
   logic [15:0] seen_a_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int pick(input int n, input logic [15:0] v, input int last);
      for (int k = 1; k <= n; k++)
         if (v[(last + k) % n]) return (last + k) % n;
      return -1;
   endfunction

   function automatic void model_reset();
      m_last[0] = 15; m_last[1] = 4;
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 1'b0; m_data[i] = '0; m_tid[i] = 0;
      end
   endfunction

   task automatic check_outputs();
      chk("a_tvalid", 64'(a_ovalid), 64'(m_valid[0]));
      chk("a_tid",    64'(a_tid),    64'(m_tid[0]));
      chk("a_tdata",  a_odata,       m_data[0]);
      chk("b_tvalid", 64'(b_ovalid), 64'(m_valid[1]));
      chk("b_tid",    64'(b_tid),    64'(m_tid[1]));
      chk("b_tdata",  b_odata,       m_data[1]);
   endtask

   // One clock: ready checked before the edge, registered outputs after it.
   task automatic step();
      int ga, gb;
      bit lea, leb;
      logic [15:0] era;
      logic [4:0]  erb;
      ga  = pick(16, a_tvalid, m_last[0]);
      gb  = pick(5, 16'(b_tvalid), m_last[1]);
      lea = !m_valid[0] || a_oready;
      leb = !m_valid[1] || b_oready;
      era = (lea && ga >= 0) ? (16'(1) << ga) : 16'h0;
      erb = (leb && gb >= 0) ? (5'(1) << gb) : 5'h0;
      @(negedge clk);
      seen_a_ready = a_tready;
      chk("a_tready", 64'(a_tready), 64'(era));
      chk("b_tready", 64'(b_tready), 64'(erb));
      @(posedge clk);
      if (lea) begin
         m_valid[0] = (ga >= 0);
         if (ga >= 0) begin
            m_data[0] = a_tdata[64*ga +: 64]; m_tid[0] = ga; m_last[0] = ga;
         end
      end
      if (leb) begin
         m_valid[1] = (gb >= 0);
         if (gb >= 0) begin
            m_data[1] = b_tdata[64*gb +: 64]; m_tid[1] = gb; m_last[1] = gb;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_a_tvalid", 64'(a_ovalid), 64'(0));
      chk("rst_a_tready", 64'(a_tready), 64'(0));
      chk("rst_b_tvalid", 64'(b_ovalid), 64'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rstn = 1'b1;
   endtask

   function automatic void set_a_words();
      for (int i = 0; i < 16; i++) a_tdata[64*i +: 64] = 64'h1200 + 64'(i);
   endfunction

   typedef struct {
      logic [15:0] valid;
      logic        oready;
      logic [15:0] exp_ready;
      logic        exp_ovalid;
      logic [3:0]  exp_tid;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3};
      tbl[1] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd3};
      tbl[2] = '{16'h0080, 1'b1, 16'h0080, 1'b1, 4'd7};
      tbl[3] = '{16'h0084, 1'b1, 16'h0004, 1'b1, 4'd2};
      tbl[4] = '{16'h0084, 1'b1, 16'h0080, 1'b1, 4'd7};
      tbl[5] = '{16'h0084, 1'b1, 16'h0004, 1'b1, 4'd2};
      tbl[6] = '{16'h0084, 1'b1, 16'h0080, 1'b1, 4'd7};
      tbl[7] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd7};

      rstn = 1'b0;
      a_tdata = '0; a_tvalid = '0; a_oready = 1'b1;
      b_tdata = '0; b_tvalid = '0; b_oready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("por_a_tready", 64'(a_tready), 64'(0));
      check_outputs();
      rstn = 1'b1;

      // Vector table: single beat on lane 3, then lanes 2/7 alternating.
      set_a_words();
      for (int i = 0; i < 8; i++) begin
         a_tvalid = tbl[i].valid;
         a_oready = tbl[i].oready;
         step();
         chk("tbl_ready",  64'(seen_a_ready), 64'(tbl[i].exp_ready));
         chk("tbl_ovalid", 64'(a_ovalid), 64'(tbl[i].exp_ovalid));
         if (tbl[i].exp_ovalid) begin
            chk("tbl_tid",   64'(a_tid), 64'(tbl[i].exp_tid));
            chk("tbl_tdata", a_odata, 64'h1200 + 64'(tbl[i].exp_tid));
         end
         a_tvalid = '0;
      end

      // All lanes valid from reset: 0..15 then back to 0, one per cycle.
      do_reset();
      a_tvalid = 16'hFFFF;
      for (int k = 0; k < 17; k++) begin
         step();
         chk("rr_tid", 64'(a_tid), 64'(k % 16));
         chk("rr_ready", 64'(seen_a_ready), 64'(16'(1) << (k % 16)));
      end
      a_tvalid = '0;
      step();

      // Backpressure: beat A from lane 5 held while lanes 5 and 6 stay valid.
      a_tdata[64*5 +: 64] = 64'hA5A5_0000_0000_0505;
      a_tvalid = 16'h0020;
      a_oready = 1'b1;
      step();
      a_tdata[64*5 +: 64] = 64'hB6B6_0000_0000_0605;
      a_tvalid = 16'h0060;
      a_oready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stall_ready", 64'(seen_a_ready), 64'(0));
         chk("stall_tdata", a_odata, 64'hA5A5_0000_0000_0505);
         chk("stall_tid",   64'(a_tid), 64'(5));
      end
      a_oready = 1'b1;
      step();
      chk("drain_ready", 64'(seen_a_ready), 64'(16'h0040));
      chk("drain_tid",   64'(a_tid), 64'(6));
      a_tvalid = '0;
      step();

      // Five lanes: wrap from 4 to 0 and back.
      do_reset();
      for (int i = 0; i < 5; i++) b_tdata[64*i +: 64] = 64'h5500 + 64'(i);
      b_tvalid = 5'b10000;
      step();
      chk("w5_first", 64'(b_tid), 64'(4));
      b_tvalid = 5'b10001;
      step();
      chk("w5_wrap", 64'(b_tid), 64'(0));
      step();
      chk("w5_back", 64'(b_tid), 64'(4));
      b_tvalid = '0;
      step();

      // Asynchronous reset while a beat is held.
      set_a_words();
      a_tvalid = 16'h0004;
      a_oready = 1'b0;
      step();
      a_tvalid = 16'h0210;
      step();
      chk("pre_rst_valid", 64'(a_ovalid), 64'(1));
      rstn = 1'b0;
      #1;
      chk("async_rst_tvalid", 64'(a_ovalid), 64'(0));
      chk("async_rst_tready", 64'(a_tready), 64'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      a_oready = 1'b1;
      step();
      chk("post_rst_tid", 64'(a_tid), 64'(4));
      a_tvalid = '0;

      // Random traffic on both instances against the model.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 16; i++) a_tdata[64*i +: 64] = {$urandom, $urandom};
         for (int i = 0; i < 5; i++)  b_tdata[64*i +: 64] = {$urandom, $urandom};
         a_tvalid = 16'($urandom) & 16'($urandom);
         b_tvalid = 5'($urandom);
         a_oready = ($urandom_range(3) != 0);
         b_oready = ($urandom_range(3) != 0);
         step();
         chk("rnd_a_onehot", 64'($onehot0(seen_a_ready)), 64'(1));
         chk("rnd_b_tid_range", 64'(b_tid < 3'd5), 64'(1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
